// File: rtl/i2c_core_pkg.sv
// Shared types for the I2C target responder.
// State encoding, ACK levels and bit-counter width.
package i2c_core_pkg;

  localparam int BIT_CNT_W = 4;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE_S,
    ADDR_S,
    ADDR_ACK_S,
    WR_BYTE_S,
    WR_ACK_S,
    RD_BYTE_S,
    RD_ACK_S
  } tgt_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one bus line.
// Strobes are asserted in the first cycle the filtered level shows the new value.
module i2c_line_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (sync_q[1] != lvl_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CW'(FILTER_LEN)) begin
        lvl_d = sync_q[1];
        cnt_d = '0;
      end
    end
    rise_d = lvl_d & ~lvl_q;
    fall_d = ~lvl_d & lvl_q;
  end

  // Idle bus is high, so everything resets to the released level.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= 2'b11;
      lvl_q  <= 1'b1;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level_o = lvl_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target responder mapping bus transfers onto an 8-bit register port.
// START/STOP detection and the transfer FSM live here.
module i2c_target_regs
  import i2c_core_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR     = 7'h48,
  parameter int         SYS_CLK_FREQ_HZ = 25000000,
  parameter int         I2C_FREQ_HZ     = 100000,
  parameter int         FILTER_LEN      = 3
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_write_o,
  output logic       reg_read_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  if (SYS_CLK_FREQ_HZ < 10 * I2C_FREQ_HZ) begin : g_bad_clk
    $error("SYS_CLK_FREQ_HZ must be >= 10*I2C_FREQ_HZ");
  end

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(8);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .line_i (scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .line_i (sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;

  tgt_state_e           state_q, state_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]           sh_q, sh_d;
  logic                 rw_q, rw_d;
  logic                 first_q, first_d;
  logic                 sda_oe_q, sda_oe_d;
  logic [7:0]           reg_addr_q, reg_addr_d;
  logic [7:0]           reg_wdata_q, reg_wdata_d;
  logic                 reg_write_q, reg_write_d;
  logic                 reg_read_q, reg_read_d;
  logic [1:0]           rd_dly_q, rd_dly_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    rw_d        = rw_q;
    first_d     = first_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_write_d = 1'b0;
    reg_read_d  = 1'b0;
    rd_dly_d    = {rd_dly_q[0], reg_read_q};
    busy_d      = busy_q;

    // Pointer advances the cycle after each write strobe.
    if (reg_write_q) reg_addr_d = reg_addr_q + 8'd1;

    if (stop) begin
      state_d  = IDLE_S;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      rd_dly_d = '0;
    end else if (start) begin
      state_d   = ADDR_S;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      rd_dly_d  = '0;
    end else begin
      unique case (state_q)
        IDLE_S: ;
        ADDR_S: begin
          if (scl_rise) begin
            sh_d      = {sh_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall && bit_cnt_q == LAST_BIT) begin
            if (sh_q[7:1] == TARGET_ADDR) begin
              state_d  = ADDR_ACK_S;
              sda_oe_d = ~I2C_ACK;
              busy_d   = 1'b1;
              rw_d     = sh_q[0];
            end else begin
              state_d = IDLE_S;
              busy_d  = 1'b0;
            end
          end
        end
        ADDR_ACK_S: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (rw_q) begin
              reg_read_d = 1'b1;
              state_d    = RD_BYTE_S;
            end else begin
              first_d = 1'b1;
              state_d = WR_BYTE_S;
            end
          end
        end
        WR_BYTE_S: begin
          if (scl_rise) begin
            sh_d      = {sh_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall && bit_cnt_q == LAST_BIT) begin
            sda_oe_d = ~I2C_ACK;
            state_d  = WR_ACK_S;
          end
        end
        WR_ACK_S: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = WR_BYTE_S;
            if (first_q) begin
              reg_addr_d = sh_q;
              first_d    = 1'b0;
            end else begin
              reg_wdata_d = sh_q;
              reg_write_d = 1'b1;
            end
          end
        end
        RD_BYTE_S: begin
          if (rd_dly_q[1]) begin
            sh_d      = reg_rdata_i;
            sda_oe_d  = ~reg_rdata_i[7];
            bit_cnt_d = '0;
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end else if (scl_fall) begin
            if (bit_cnt_q == LAST_BIT) begin
              sda_oe_d = 1'b0;
              state_d  = RD_ACK_S;
            end else begin
              sh_d     = {sh_q[6:0], 1'b0};
              sda_oe_d = ~sh_q[6];
            end
          end
        end
        RD_ACK_S: begin
          if (scl_rise) begin
            sh_d[0] = sda_lvl;
          end else if (scl_fall) begin
            if (sh_q[0] == I2C_ACK) begin
              reg_addr_d = reg_addr_q + 8'd1;
              reg_read_d = 1'b1;
              bit_cnt_d  = '0;
              state_d    = RD_BYTE_S;
            end else begin
              state_d = IDLE_S;
            end
          end
        end
        default: state_d = IDLE_S;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= IDLE_S;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      rd_dly_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_write_q <= reg_write_d;
      reg_read_q  <= reg_read_d;
      rd_dly_q    <= rd_dly_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_oe_o    = sda_oe_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_write_o = reg_write_q;
  assign reg_read_o  = reg_read_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bus-model master drives SCL/SDA against the target.
// Register port stub returns addr^0x5A; writes and strobes are logged.
module tb_i2c_target_regs;
  import i2c_core_pkg::*;

  localparam int Q = 63;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe_o;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_write_o;
  logic       reg_read_o;
  logic [7:0] reg_rdata_i;
  logic       busy_o;

  int n_chk = 0;
  int n_fail = 0;
  int n_rd = 0;
  int n_oe = 0;
  int n_busy = 0;
  logic [7:0] wa[$];
  logic [7:0] wd[$];

  assign sda_bus = sda_m & ~sda_oe_o;
  assign reg_rdata_i = reg_addr_o ^ 8'h5A;

  i2c_target_regs #(.TARGET_ADDR(7'h48)) dut (
    .clk_i      (clk),
    .arst_i     (arst),
    .scl_i      (scl_m),
    .sda_i      (sda_bus),
    .sda_oe_o   (sda_oe_o),
    .reg_addr_o (reg_addr_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_write_o(reg_write_o),
    .reg_read_o (reg_read_o),
    .reg_rdata_i(reg_rdata_i),
    .busy_o     (busy_o)
  );

  always #20 clk = ~clk;

  always @(posedge clk) begin
    if (reg_write_o) begin
      wa.push_back(reg_addr_o);
      wd.push_back(reg_wdata_o);
    end
    if (reg_read_o) n_rd++;
    if (sda_oe_o) n_oe++;
    if (busy_o) n_busy++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic put_bit(input logic b, input bit gl);
    sda_m = b;
    if (gl) begin
      repeat (10) @(negedge clk);
      scl_m = 1'b1;
      repeat (2) @(negedge clk);
      scl_m = 1'b0;
      repeat (Q - 12) @(negedge clk);
    end else begin
      wq();
    end
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic wr_byte(input logic [7:0] d, input bit gl,
                         output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i], gl);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    ack = sda_bus; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wq(); scl_m = 1'b1;
      wq(); d[i] = sda_bus;
      wq(); scl_m = 1'b0;
    end
    wq(); sda_m = mack;
    wq(); scl_m = 1'b1;
    wq(); wq(); scl_m = 1'b0;
    wq();
  endtask

  task automatic sc_basic(input string p);
    logic ack;
    int b;
    b = wa.size();
    i2c_start();
    wr_byte(8'h90, 1'b0, ack);
    chk({p, "_addr_ack"}, 32'(ack), 32'(I2C_ACK));
    chk({p, "_busy_on"}, 32'(busy_o), 1);
    wr_byte(8'h10, 1'b0, ack);
    chk({p, "_ptr_ack"}, 32'(ack), 0);
    wr_byte(8'hAA, 1'b0, ack);
    chk({p, "_d0_ack"}, 32'(ack), 0);
    wr_byte(8'hBB, 1'b0, ack);
    chk({p, "_d1_ack"}, 32'(ack), 0);
    i2c_stop();
    repeat (20) @(negedge clk);
    chk({p, "_nwr"}, 32'(wa.size() - b), 2);
    chk({p, "_wa0"}, 32'(wa[b]), 32'h10);
    chk({p, "_wd0"}, 32'(wd[b]), 32'hAA);
    chk({p, "_wa1"}, 32'(wa[b+1]), 32'h11);
    chk({p, "_wd1"}, 32'(wd[b+1]), 32'hBB);
    chk({p, "_busy_off"}, 32'(busy_o), 0);
    chk({p, "_ptr_end"}, 32'(reg_addr_o), 32'h12);
  endtask

  initial begin
    logic ack;
    logic [7:0] d;
    int b, r, o, bz;

    repeat (5) @(negedge clk);
    chk("rst_oe", 32'(sda_oe_o), 0);
    chk("rst_addr", 32'(reg_addr_o), 0);
    chk("rst_wdata", 32'(reg_wdata_o), 0);
    chk("rst_wr", 32'(reg_write_o), 0);
    chk("rst_rd", 32'(reg_read_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    arst = 1'b0;
    repeat (10) @(negedge clk);

    sc_basic("s1");

    b = wa.size();
    r = n_rd;
    i2c_start();
    wr_byte(8'h90, 1'b0, ack);
    wr_byte(8'h20, 1'b0, ack);
    chk("s2_ptr_ack", 32'(ack), 0);
    i2c_start();
    wr_byte(8'h91, 1'b0, ack);
    chk("s2_raddr_ack", 32'(ack), 0);
    rd_byte(I2C_ACK, d);
    chk("s2_rd0", 32'(d), 32'h7A);
    rd_byte(I2C_NACK, d);
    chk("s2_rd1", 32'(d), 32'h7B);
    chk("s2_busy_nack", 32'(busy_o), 1);
    chk("s2_oe_nack", 32'(sda_oe_o), 0);
    i2c_stop();
    repeat (20) @(negedge clk);
    chk("s2_nrd", 32'(n_rd - r), 2);
    chk("s2_nwr", 32'(wa.size() - b), 0);
    chk("s2_ptr_end", 32'(reg_addr_o), 32'h21);
    chk("s2_busy_off", 32'(busy_o), 0);

    b = wa.size();
    r = n_rd;
    o = n_oe;
    bz = n_busy;
    i2c_start();
    wr_byte(8'h92, 1'b0, ack);
    chk("s3_nack", 32'(ack), 1);
    wr_byte(8'h55, 1'b0, ack);
    chk("s3_data_nack", 32'(ack), 1);
    i2c_stop();
    repeat (20) @(negedge clk);
    chk("s3_oe_cnt", 32'(n_oe - o), 0);
    chk("s3_busy_cnt", 32'(n_busy - bz), 0);
    chk("s3_nwr", 32'(wa.size() - b), 0);
    chk("s3_nrd", 32'(n_rd - r), 0);

    b = wa.size();
    i2c_start();
    wr_byte(8'h90, 1'b0, ack);
    wr_byte(8'hFF, 1'b0, ack);
    wr_byte(8'h11, 1'b1, ack);
    chk("s4_glitch_ack", 32'(ack), 0);
    wr_byte(8'h22, 1'b0, ack);
    i2c_stop();
    repeat (20) @(negedge clk);
    chk("s4_nwr", 32'(wa.size() - b), 2);
    chk("s4_wa0", 32'(wa[b]), 32'hFF);
    chk("s4_wd0", 32'(wd[b]), 32'h11);
    chk("s4_wa1", 32'(wa[b+1]), 32'h00);
    chk("s4_wd1", 32'(wd[b+1]), 32'h22);
    chk("s4_ptr_end", 32'(reg_addr_o), 32'h01);

    b = wa.size();
    i2c_start();
    wr_byte(8'h90, 1'b0, ack);
    wr_byte(8'h40, 1'b0, ack);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    put_bit(1'b1, 1'b0);
    put_bit(1'b0, 1'b0);
    i2c_stop();
    repeat (20) @(negedge clk);
    chk("s5_nwr", 32'(wa.size() - b), 0);
    chk("s5_state", 32'(dut.state_q), 32'(IDLE_S));
    chk("s5_oe", 32'(sda_oe_o), 0);
    chk("s5_busy", 32'(busy_o), 0);
    chk("s5_ptr", 32'(reg_addr_o), 32'h40);

    i2c_start();
    wr_byte(8'h90, 1'b0, ack);
    wr_byte(8'h30, 1'b0, ack);
    i2c_start();
    wr_byte(8'h91, 1'b0, ack);
    chk("s6_oe_pre", 32'(sda_oe_o), 1);
    arst = 1'b1;
    #1;
    chk("s6_oe_rst", 32'(sda_oe_o), 0);
    chk("s6_addr_rst", 32'(reg_addr_o), 0);
    chk("s6_busy_rst", 32'(busy_o), 0);
    @(negedge clk);
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
    arst = 1'b0;
    repeat (20) @(negedge clk);
    sc_basic("s6");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
